// File: rtl/rv32_control_fsm_if.sv
// Memory handshake bundle between the control sequencer and the instruction and
// data memories. The sequencer is the master: it raises the requests, and the
// memories answer with the ready strobes.
interface rv32_control_fsm_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/rv32_control_fsm.sv
// Multi-cycle control sequencer for the RV32 core.
// Walks FETCH -> DECODE -> EXECUTE -> (MEM) -> WB for legal instructions and
// diverts illegal or SYSTEM instructions and memory timeouts to TRAP, which
// loads the trap vector into the PC. All control outputs are decoded from the
// current state and the opcode captured in DECODE.
module rv32_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    rv32_control_fsm_if.master mem,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    output logic        ir_load,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_load,
    output logic [1:0]  pc_src,
    output logic        trap_valid,
    output logic [1:0]  trap_cause,
    output logic        retire,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_ILLEGAL = 2'd0,
        C_SYSTEM  = 2'd1,
        C_IMEM_TO = 2'd2,
        C_DMEM_TO = 2'd3
    } cause_t;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Wait counter only has to reach TIMEOUT_CYCLES-1, so size it to that.
    localparam int          CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic [31:0]      instret_q;
    logic             waiting;
    logic             timeout_hit;

    // The captured funct3 is not needed after DECODE today (legality is
    // resolved there), but it is kept so later states can qualify on it.
    logic unused_f3;
    assign unused_f3 = ^f3_q;

    function automatic logic op_is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL,
            OP_OP_IMM, OP_OP, OP_MISC_MEM: return 1'b1;
            OP_JALR:   return f3 == 3'b000;
            OP_BRANCH: return !(f3 inside {3'b010, 3'b011});
            OP_LOAD:   return !(f3 inside {3'b011, 3'b110, 3'b111});
            OP_STORE:  return f3 < 3'd3;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // PC feeds ALU operand A for PC-relative forms.
    function automatic logic op_src_a(input logic [6:0] op);
        return (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_BRANCH);
    endfunction

    // Immediate feeds ALU operand B for every immediate-carrying form.
    function automatic logic op_src_b(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_OP_IMM);
    endfunction

    assign waiting     = ((state_q == S_FETCH) && !mem.imem_ready) ||
                         ((state_q == S_MEM)   && !mem.dmem_ready);
    assign timeout_hit = TO_EN && (cnt_q == CNT_LIMIT);

    // State, trap cause and wait-counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= C_ILLEGAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, trap-cause and wait-counter logic.
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem.imem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = C_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_d = S_TRAP;
                    cause_d = C_SYSTEM;
                end else if (!op_is_legal(opcode, funct3)) begin
                    state_d = S_TRAP;
                    cause_d = C_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = op_is_mem(op_q) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem.dmem_ready) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = C_DMEM_TO;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        // Counts only while stalled in a wait state; any exit or fresh entry restarts it.
        cnt_d = (waiting && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
    end

    // Instruction fields captured in DECODE and the retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            f3_q      <= '0;
            instret_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
            end
            if (state_q == S_WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Control outputs decoded from the current state and the captured opcode.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_load      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        pc_load      = 1'b0;
        pc_src       = 2'd0;
        trap_valid   = 1'b0;
        retire       = 1'b0;
        // ALU operands stay selected through MEM and WB, where the ALU result is
        // consumed as the memory address, writeback value or jump target.
        if (state_q inside {S_EXECUTE, S_MEM, S_WB}) begin
            alu_src_a = op_src_a(op_q);
            alu_src_b = op_src_b(op_q);
        end
        case (state_q)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                ir_load      = mem.imem_ready;
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (op_q == OP_STORE);
            end
            S_WB: begin
                pc_load = 1'b1;
                retire  = 1'b1;
                rf_we   = (op_q == OP_LUI) || (op_q == OP_AUIPC) || (op_q == OP_JAL) ||
                          (op_q == OP_JALR) || (op_q == OP_OP) || (op_q == OP_OP_IMM) ||
                          (op_q == OP_LOAD);
                case (op_q)
                    OP_LOAD:          wb_sel = 2'd1;
                    OP_JAL, OP_JALR:  wb_sel = 2'd2;
                    OP_LUI:           wb_sel = 2'd3;
                    default:          wb_sel = 2'd0;
                endcase
                case (op_q)
                    OP_JAL:    pc_src = 2'd1;
                    OP_JALR:   pc_src = 2'd2;
                    OP_BRANCH: pc_src = branch_taken ? 2'd1 : 2'd0;
                    default:   pc_src = 2'd0;
                endcase
            end
            S_TRAP: begin
                trap_valid = 1'b1;
                pc_load    = 1'b1;
                pc_src     = 2'd3;
            end
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rv32_control_fsm.sv
// Self-checking bench for rv32_control_fsm. Each task drives one scenario a
// cycle at a time and pushes the cycle's expected outputs into a scoreboard;
// a negedge monitor pops and compares them against the DUT.
module tb_rv32_control_fsm;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [2:0]  state;
        logic        imem_req;
        logic        ir_load;
        logic        dmem_req;
        logic        dmem_we;
        logic        alu_a;
        logic        alu_b;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        pc_load;
        logic [1:0]  pc_src;
        logic        trap_valid;
        logic [1:0]  trap_cause;
        logic        retire;
        logic [31:0] instret;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic        ir_load, alu_src_a, alu_src_b, rf_we, pc_load, trap_valid, retire;
    logic [1:0]  wb_sel, pc_src, trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    rv32_control_fsm_if mem_if ();

    rv32_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (mem_if),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .ir_load      (ir_load),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .retire       (retire),
        .instret      (instret),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    string       cur_test = "none";
    logic [31:0] exp_instret = '0;
    logic [1:0]  exp_cause   = '0;

    // Scoreboard consumer: one comparison per driven cycle.
    always @(negedge clk) begin
        exp_t want;
        exp_t got;
        if (sb.size() != 0) begin
            want = sb.pop_front();
            got.state      = state;
            got.imem_req   = mem_if.imem_req;
            got.ir_load    = ir_load;
            got.dmem_req   = mem_if.dmem_req;
            got.dmem_we    = mem_if.dmem_we;
            got.alu_a      = alu_src_a;
            got.alu_b      = alu_src_b;
            got.rf_we      = rf_we;
            got.wb_sel     = wb_sel;
            got.pc_load    = pc_load;
            got.pc_src     = pc_src;
            got.trap_valid = trap_valid;
            got.trap_cause = trap_cause;
            got.retire     = retire;
            got.instret    = instret;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: actual %h required %h", cur_test, cyc, got, want);
            end
            cyc++;
        end
    end

    function automatic exp_t e_base(input logic [2:0] s);
        exp_t e;
        e            = '0;
        e.state      = s;
        e.trap_cause = exp_cause;
        e.instret    = exp_instret;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic ld);
        exp_t e;
        e          = e_base(3'd0);
        e.imem_req = 1'b1;
        e.ir_load  = ld;
        return e;
    endfunction

    function automatic exp_t e_decode();
        return e_base(3'd1);
    endfunction

    function automatic exp_t e_exec(input logic a, input logic b);
        exp_t e;
        e       = e_base(3'd2);
        e.alu_a = a;
        e.alu_b = b;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic we);
        exp_t e;
        e          = e_base(3'd3);
        e.dmem_req = 1'b1;
        e.dmem_we  = we;
        e.alu_b    = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic a, input logic b, input logic rf,
                                  input logic [1:0] wbs, input logic [1:0] pcs);
        exp_t e;
        e         = e_base(3'd4);
        e.alu_a   = a;
        e.alu_b   = b;
        e.rf_we   = rf;
        e.wb_sel  = wbs;
        e.pc_load = 1'b1;
        e.pc_src  = pcs;
        e.retire  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_trap();
        exp_t e;
        e            = e_base(3'd5);
        e.trap_valid = 1'b1;
        e.pc_load    = 1'b1;
        e.pc_src     = 2'd3;
        return e;
    endfunction

    // Drive one cycle of memory handshakes and queue that cycle's expectation.
    task automatic step(input logic ir, input logic dr, input exp_t e);
        mem_if.imem_ready = ir;
        mem_if.dmem_ready = dr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic bt);
        opcode       = op;
        funct3       = f3;
        branch_taken = bt;
    endtask

    // Zero-wait ALU/branch/jump instruction: FETCH, DECODE, EXECUTE, WB.
    task automatic run_short(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                             input logic a, input logic b, input logic rf,
                             input logic [1:0] wbs, input logic [1:0] pcs);
        set_instr(op, f3, bt);
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        step(1'b0, 1'b0, e_exec(a, b));
        step(1'b0, 1'b0, e_wb(a, b, rf, wbs, pcs));
        exp_instret = exp_instret + 32'd1;
    endtask

    // Load/store with dwait stalled MEM cycles before dmem_ready.
    task automatic run_mem(input logic [6:0] op, input logic [2:0] f3, input logic we,
                           input logic rf, input logic [1:0] wbs, input int dwait);
        set_instr(op, f3, 1'b0);
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        step(1'b0, 1'b0, e_exec(1'b0, 1'b1));
        for (int i = 0; i < dwait; i++) step(1'b0, 1'b0, e_mem(we));
        step(1'b0, 1'b1, e_mem(we));
        step(1'b0, 1'b0, e_wb(1'b0, 1'b1, rf, wbs, 2'd0));
        exp_instret = exp_instret + 32'd1;
    endtask

    // Instruction rejected in DECODE: FETCH, DECODE, TRAP.
    task automatic run_trap(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] cause);
        set_instr(op, f3, 1'b0);
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        exp_cause = cause;
        step(1'b0, 1'b0, e_trap());
    endtask

    task automatic test_reset();
        cur_test = "reset";
        step(1'b0, 1'b0, e_fetch(1'b0));
        step(1'b0, 1'b0, e_fetch(1'b0));
        rst_n = 1'b1;
        step(1'b0, 1'b0, e_fetch(1'b0));
    endtask

    task automatic test_addi();
        cur_test = "addi";
        run_short(OP_OP_IMM, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    endtask

    task automatic test_load();
        cur_test = "lw_wait3";
        run_mem(OP_LOAD, 3'b010, 1'b0, 1'b1, 2'd1, 3);
    endtask

    task automatic test_branch();
        cur_test = "beq_taken";
        run_short(OP_BRANCH, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        cur_test = "beq_not_taken";
        run_short(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        cur_test = "jalr_bad_f3";
        run_trap(OP_JALR, 3'b001, 2'd0);
    endtask

    task automatic test_ops();
        cur_test = "jal";
        run_short(OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1);
        cur_test = "jalr";
        run_short(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2);
        cur_test = "lui";
        run_short(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        cur_test = "auipc";
        run_short(OP_AUIPC, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
        cur_test = "op_add";
        run_short(OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        cur_test = "fence";
        run_short(OP_MISC_MEM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        cur_test = "sw";
        run_mem(OP_STORE, 3'b010, 1'b1, 1'b0, 2'd0, 0);
    endtask

    task automatic test_illegal();
        cur_test = "unknown_opcode";
        run_trap(7'b0000000, 3'b000, 2'd0);
        cur_test = "load_f3_011";
        run_trap(OP_LOAD, 3'b011, 2'd0);
        cur_test = "store_f3_011";
        run_trap(OP_STORE, 3'b011, 2'd0);
        cur_test = "branch_f3_010";
        run_trap(OP_BRANCH, 3'b010, 2'd0);
    endtask

    task automatic test_ecall();
        cur_test = "ecall";
        run_trap(OP_SYSTEM, 3'b000, 2'd1);
    endtask

    task automatic test_imem_timeout();
        cur_test = "imem_timeout";
        set_instr(OP_OP_IMM, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, e_fetch(1'b0));
        exp_cause = 2'd2;
        step(1'b0, 1'b0, e_trap());
        cur_test = "imem_ready_at_limit";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_fetch(1'b0));
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        step(1'b0, 1'b0, e_exec(1'b0, 1'b1));
        step(1'b0, 1'b0, e_wb(1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
        exp_instret = exp_instret + 32'd1;
    endtask

    task automatic test_dmem_timeout();
        cur_test = "dmem_timeout";
        set_instr(OP_LOAD, 3'b010, 1'b0);
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        step(1'b0, 1'b0, e_exec(1'b0, 1'b1));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, e_mem(1'b0));
        exp_cause = 2'd3;
        step(1'b0, 1'b0, e_trap());
    endtask

    task automatic test_instret_wrap();
        cur_test = "instret_wrap";
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        run_short(OP_OP_IMM, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        n_checks++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL instret_wrap: actual %h required %h", instret, 32'd0);
        end
    endtask

    task automatic test_reset_mid_mem();
        cur_test = "reset_mid_mem";
        set_instr(OP_LOAD, 3'b010, 1'b0);
        step(1'b1, 1'b0, e_fetch(1'b1));
        step(1'b0, 1'b0, e_decode());
        step(1'b0, 1'b0, e_exec(1'b0, 1'b1));
        step(1'b0, 1'b0, e_mem(1'b0));
        n_checks++;
        if (mem_if.dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mem_req_before_reset: actual %b required %b", mem_if.dmem_req, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_if.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_dmem_req: actual %b required %b", mem_if.dmem_req, 1'b0);
        end
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_state: actual %0d required %0d", state, 0);
        end
        n_checks++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_instret: actual %h required %h", instret, 32'd0);
        end
        n_checks++;
        if ({mem_if.imem_req, trap_cause} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset_fetch_cause: actual %b required %b",
                     {mem_if.imem_req, trap_cause}, 3'b100);
        end
        exp_instret = '0;
        exp_cause   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur_test = "after_reset_addi";
        run_short(OP_OP_IMM, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        step(1'b0, 1'b0, e_fetch(1'b0));
    endtask

    initial begin
        rst_n             = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        set_instr(7'd0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_ops();
        test_illegal();
        test_ecall();
        test_imem_timeout();
        test_dmem_timeout();
        test_instret_wrap();
        test_reset_mid_mem();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries left required %0d", sb.size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual timeout at %0t required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/rv32_control_fsm.md
Name: rv32_control_fsm

Overview:
- Multi-cycle control sequencer for the RV32 core.
- Drives instruction fetch, latches the IR, and consumes the combinational instruction decoder's opcode/funct3 fields.
- Sequences ALU, data-memory and register-file writeback, and steers the PC mux.
- Detects illegal or SYSTEM instructions and memory timeouts, and redirects to the trap vector.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for imem_ready/dmem_ready before trapping; 0 disables timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  decoder opcode field, valid from DECODE onward
- funct3  in  3  decoder funct3 field
- branch_taken  in  1  ALU compare result, valid in EXECUTE/WB
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  capture instruction into IR
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=immediate
- rf_we  out  1  register file write enable
- wb_sel  out  2  0=ALU, 1=mem, 2=PC+4, 3=immediate
- pc_load  out  1  update PC
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result, 3=trap vector
- trap_valid  out  1  one-cycle pulse in TRAP
- trap_cause  out  2  0=illegal, 1=SYSTEM, 2=imem timeout, 3=dmem timeout
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  32  retired-instruction counter
- state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5. Encodings 6-7 go to FETCH.
- Reset (async, rst_n low):
  - state=FETCH, instret=0, trap_cause=0, timeout counter=0, latched opcode/funct3=0.
  - All outputs are 0 except imem_req=1 (FETCH). Reset mid-operation drops dmem_req immediately.
- FETCH:
  - imem_req=1 held until imem_ready.
  - On imem_ready, ir_load=1 in the same cycle, then go to DECODE.
- DECODE:
  - Latch opcode/funct3 into internal registers; later states use the latched copies.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM.
  - Illegal, cause 0:
    - unknown opcode
    - JALR with funct3≠0
    - BRANCH with funct3 010/011
    - LOAD with funct3 011/110/111
    - STORE with funct3≥3
  - SYSTEM (1110011) → TRAP with cause 1. Otherwise → EXECUTE.
- EXECUTE:
  - AUIPC/JAL/BRANCH: alu_src_a=1.
  - Immediate forms: alu_src_b=1.
  - LOAD/STORE → MEM; everything else → WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only.
  - Hold until dmem_ready, then go to WB.
- WB:
  - pc_load=1, retire=1, instret+=1 (wraps 0xFFFFFFFF→0), then → FETCH.
  - rf_we=1 for LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD. It is 0 for BRANCH, STORE, MISC-MEM (FENCE executes as NOP).
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_src: JAL=1, JALR=2, BRANCH=(branch_taken?1:0), else 0.
- TRAP:
  - trap_valid=1, pc_load=1, pc_src=3 for one cycle, then → FETCH.
  - No retire, no rf_we. trap_cause holds until the next trap.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle waiting without ready.
  - When it equals TIMEOUT_CYCLES−1 and ready is low → TRAP with cause 2 (FETCH) or 3 (MEM).
  - ready in the same cycle as the limit: ready wins. TIMEOUT_CYCLES=0 disables the timeout.
- Latency with zero-wait memory:
  - ALU/branch/jump: 4 cycles.
  - Load/store: 5 cycles.
  - Illegal: 3 cycles (FETCH, DECODE, TRAP).
- All control outputs are combinational from state plus the latched opcode. No output is asserted outside its state.

Test Plan:
- Reset, then ADDI (opcode 0010011) with imem_ready=1 every cycle → states 0,1,2,4,0; in WB rf_we=1, wb_sel=0, alu_src_b=1, pc_src=0, retire=1; instret=1.
- LW (opcode 0000011, funct3 010), dmem_ready delayed 3 cycles → dmem_req=1, dmem_we=0 for 4 cycles; WB has wb_sel=1, rf_we=1; total 8 cycles.
- BEQ with branch_taken=1, then again with branch_taken=0 → WB pc_src=1 then 0, rf_we=0 both times; JALR with funct3=001 → TRAP, cause 0, no retire.
- ECALL (0x00000073) → TRAP after DECODE, trap_valid pulse 1 cycle, cause 1, pc_src=3; next cycle state=FETCH, instret unchanged.
- TIMEOUT_CYCLES=4, imem_ready held low → TRAP after 4 FETCH cycles with cause 2; repeat with ready on the 4th cycle → DECODE, no trap.
- Deassert rst_n mid-MEM with dmem_req high → dmem_req=0 and state=0 asynchronously; instret cleared; preset instret=0xFFFFFFFF then retire → 0.
